// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multicycle MIPS control path
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BLTEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_LUIEX   = 4'd11,
    S_LIEX    = 4'd12,
    S_IMMWB   = 4'd13,
    S_JEX     = 4'd14
  } statetype_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LI    = 6'b110000;
  localparam logic [5:0] OP_BLT   = 6'b011000;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_A    = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [2:0] SRCB_B      = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_SIMM   = 3'b010;
  localparam logic [2:0] SRCB_SIMMSH = 3'b011;
  localparam logic [2:0] SRCB_UIMM   = 3'b100;
  localparam logic [2:0] SRCB_ZIMM   = 3'b101;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       bltbranch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mainfsm_outdec.sv
// rtl/mainfsm_outdec.sv - combinational state to control-word decode
module mainfsm_outdec
  import mips_pkg::*;
(
  input  statetype_t i_state,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.irwrite = 1'b1;
        o_ctrl.alusrcb = SRCB_FOUR;
        o_ctrl.pcwrite = 1'b1;
      end
      S_DECODE:  o_ctrl.alusrcb = SRCB_SIMMSH;
      S_MEMADR: begin
        o_ctrl.alusrca = SRCA_A;
        o_ctrl.alusrcb = SRCB_SIMM;
      end
      S_MEMRD:   o_ctrl.iord = 1'b1;
      S_MEMWB: begin
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        o_ctrl.alusrca = SRCA_A;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      S_BEQEX, S_BLTEX: begin
        o_ctrl.alusrca   = SRCA_A;
        o_ctrl.aluop     = ALUOP_SUB;
        o_ctrl.pcsrc     = PCSRC_ALUOUT;
        o_ctrl.branch    = (i_state == S_BEQEX);
        o_ctrl.bltbranch = (i_state == S_BLTEX);
      end
      S_ADDIEX: begin
        o_ctrl.alusrca = SRCA_A;
        o_ctrl.alusrcb = SRCB_SIMM;
      end
      S_LUIEX: begin
        o_ctrl.alusrca = SRCA_ZERO;
        o_ctrl.alusrcb = SRCB_UIMM;
      end
      S_LIEX: begin
        o_ctrl.alusrca = SRCA_ZERO;
        o_ctrl.alusrcb = SRCB_ZIMM;
      end
      S_IMMWB:   o_ctrl.regwrite = 1'b1;
      S_JEX: begin
        o_ctrl.pcsrc   = PCSRC_JUMP;
        o_ctrl.pcwrite = 1'b1;
      end
      default:   o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// rtl/mainfsm.sv - multicycle MIPS control FSM: state register, sequencing, pcen
module mainfsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       neg,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] alusrca,
  output logic [2:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop
);

  statetype_t r_state;
  statetype_t w_dec_state;
  ctrl_t      w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_RTYPEEX;
            OP_BEQ:       r_state <= S_BEQEX;
            OP_BLT:       r_state <= S_BLTEX;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JEX;
            OP_LUI:       r_state <= S_LUIEX;
            OP_LI:        r_state <= S_LIEX;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          case (op)
            OP_LW:   r_state <= S_MEMRD;
            OP_SW:   r_state <= S_MEMWR;
            default: r_state <= S_FETCH;
          endcase
        end
        S_MEMRD:   r_state <= S_MEMWB;
        S_RTYPEEX: r_state <= S_RTYPEWB;
        S_ADDIEX, S_LUIEX, S_LIEX: r_state <= S_IMMWB;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // During reset the datapath sees FETCH controls with every write strobe suppressed.
  assign w_dec_state = reset ? S_FETCH : r_state;

  mainfsm_outdec u_outdec (
    .i_state (w_dec_state),
    .o_ctrl  (w_ctrl)
  );

  assign pcen     = ~reset & (w_ctrl.pcwrite | (w_ctrl.branch & zero) | (w_ctrl.bltbranch & neg));
  assign irwrite  = ~reset & w_ctrl.irwrite;
  assign regwrite = ~reset & w_ctrl.regwrite;
  assign memwrite = ~reset & w_ctrl.memwrite;
  assign iord     = w_ctrl.iord;
  assign regdst   = w_ctrl.regdst;
  assign memtoreg = w_ctrl.memtoreg;
  assign alusrca  = w_ctrl.alusrca;
  assign alusrcb  = w_ctrl.alusrcb;
  assign pcsrc    = w_ctrl.pcsrc;
  assign aluop    = w_ctrl.aluop;

endmodule

// File: tb/tb_mainfsm.sv
// tb/tb_mainfsm.sv - scoreboard bench for mainfsm against an instruction-level reference
module tb_mainfsm;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010, LUI = 6'b001111, LI = 6'b110000;
  localparam logic [5:0] BLT = 6'b011000;

  typedef struct {
    logic [15:0] word;
    logic [5:0]  op;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = LW;
  logic zero = 1'b0, neg = 1'b0;
  logic pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic [1:0] alusrca, pcsrc, aluop;
  logic [2:0] alusrcb;

  exp_t sb[$];
  int n_total = 0;
  int n_pass = 0;

  mainfsm dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .neg(neg),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop)
  );

  always #5 clk = ~clk;

  // Packed as {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluop}
  function automatic logic [15:0] cw(input logic pe, io, mw, ir, rd, mr, rw,
                                     input logic [1:0] sa, input logic [2:0] sbv,
                                     input logic [1:0] ps, ao);
    return {pe, io, mw, ir, rd, mr, rw, sa, sbv, ps, ao};
  endfunction

  function automatic int cpi(input logic [5:0] o);
    case (o)
      LW:                      return 5;
      SW, RT, ADDI, LUI, LI:   return 4;
      BEQ, BLT, J:             return 3;
      default:                 return 2;
    endcase
  endfunction

  function automatic logic [15:0] ref_word(input logic [5:0] o, input int c, input logic z, input logic n);
    if (c == 0) return cw(1,0,0,1,0,0,0, 2'b00, 3'b001, 2'b00, 2'b00);
    if (c == 1) return cw(0,0,0,0,0,0,0, 2'b00, 3'b011, 2'b00, 2'b00);
    case (o)
      LW, SW: begin
        if (c == 2) return cw(0,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 2'b00);
        if (o == SW) return cw(0,1,1,0,0,0,0, 2'b00, 3'b000, 2'b00, 2'b00);
        if (c == 3) return cw(0,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 2'b00);
        return cw(0,0,0,0,0,1,1, 2'b00, 3'b000, 2'b00, 2'b00);
      end
      RT:   return (c == 2) ? cw(0,0,0,0,0,0,0, 2'b01, 3'b000, 2'b00, 2'b10)
                            : cw(0,0,0,0,1,0,1, 2'b00, 3'b000, 2'b00, 2'b00);
      BEQ:  return cw(z,0,0,0,0,0,0, 2'b01, 3'b000, 2'b01, 2'b01);
      BLT:  return cw(n,0,0,0,0,0,0, 2'b01, 3'b000, 2'b01, 2'b01);
      J:    return cw(1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 2'b00);
      ADDI: return (c == 2) ? cw(0,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 2'b00)
                            : cw(0,0,0,0,0,0,1, 2'b00, 3'b000, 2'b00, 2'b00);
      LUI:  return (c == 2) ? cw(0,0,0,0,0,0,0, 2'b10, 3'b100, 2'b00, 2'b00)
                            : cw(0,0,0,0,0,0,1, 2'b00, 3'b000, 2'b00, 2'b00);
      LI:   return (c == 2) ? cw(0,0,0,0,0,0,0, 2'b10, 3'b101, 2'b00, 2'b00)
                            : cw(0,0,0,0,0,0,1, 2'b00, 3'b000, 2'b00, 2'b00);
      default: return 16'h0;
    endcase
  endfunction

  function automatic logic [15:0] reset_word();
    return cw(0,0,0,0,0,0,0, 2'b00, 3'b001, 2'b00, 2'b00);
  endfunction

  task automatic drive(input logic rst, input logic [5:0] o, input logic z, input logic n,
                       input logic [15:0] e, input int c);
    exp_t x;
    @(posedge clk);
    #1;
    reset = rst; op = o; zero = z; neg = n;
    x.word = e; x.op = o; x.cyc = c;
    sb.push_back(x);
  endtask

  // zsel/nsel: 0 or 1 forces the flag, 2 randomizes it each cycle. rst_at < 0 means no reset.
  task automatic run_instr(input logic [5:0] o, input int zsel, input int nsel, input int rst_at);
    logic [5:0] ov;
    logic z, n;
    for (int c = 0; c < cpi(o); c++) begin
      ov = (c == 1 || c == 2) ? o : 6'($urandom_range(63));
      z = (zsel > 1) ? 1'($urandom_range(1)) : 1'(zsel);
      n = (nsel > 1) ? 1'($urandom_range(1)) : 1'(nsel);
      if (c == rst_at) begin
        drive(1'b1, ov, z, n, reset_word(), -1);
        return;
      end
      drive(1'b0, ov, z, n, ref_word(o, c, z, n), c);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    logic [15:0] act;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      act = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop};
      n_total++;
      if (act === x.word) n_pass++;
      else $display("FAIL ctrl op=%b cyc=%0d actual=%b required=%b", x.op, x.cyc, act, x.word);
    end
  end

  initial begin
    logic [5:0] ops [10];
    logic [5:0] ro;
    ops = '{LW, SW, RT, BEQ, ADDI, J, LUI, LI, BLT, 6'b111111};

    for (int i = 0; i < 3; i++) drive(1'b1, LW, 1'b0, 1'b0, reset_word(), -1);
    run_instr(LW, 2, 2, -1);
    run_instr(BEQ, 1, 0, -1);
    run_instr(BEQ, 0, 1, -1);
    run_instr(BLT, 0, 1, -1);
    run_instr(BLT, 1, 0, -1);
    run_instr(LUI, 2, 2, -1);
    run_instr(LI, 2, 2, -1);
    run_instr(6'b111111, 2, 2, -1);
    run_instr(SW, 2, 2, 3);
    run_instr(RT, 2, 2, -1);
    run_instr(J, 2, 2, -1);
    run_instr(ADDI, 2, 2, -1);

    for (int i = 0; i < 300; i++) begin
      ro = ($urandom_range(9) == 0) ? 6'($urandom_range(63)) : ops[$urandom_range(9)];
      if ($urandom_range(15) == 0) begin
        run_instr(ro, 2, 2, int'($urandom_range(cpi(ro) - 1)));
        if ($urandom_range(1) == 1) drive(1'b1, 6'($urandom_range(63)), 1'b0, 1'b0, reset_word(), -1);
      end else begin
        run_instr(ro, 2, 2, -1);
      end
    end

    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
